// File: rtl/pipeline_sequencer.sv
// Stall/flush/run controller for the five-stage MIPS pipeline plus debug run/step/halt sequencing.
// Optional performance counters are enabled by defining PIPE_SEQ_PERF_COUNTERS_EN.
module pipeline_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_DBG_RUN,
  input  logic        I_DBG_MODE,
  input  logic        I_DBG_STEP,
  input  logic        I_HALT_WB,
  input  logic        I_IDEX_MemRead,
  input  logic [4:0]  I_IDEX_RT,
  input  logic [4:0]  I_IFID_RS,
  input  logic [4:0]  I_IFID_RT,
  input  logic        I_BRANCH_TAKEN,
  output logic        O_PC_ENABLE,
  output logic        O_IFID_ENABLE,
  output logic        O_IFID_FLUSH,
  output logic        O_IDEX_ENABLE,
  output logic        O_IDEX_BUBBLE,
  output logic        O_EXMEM_ENABLE,
  output logic        O_MEMWB_ENABLE,
  output logic [2:0]  O_STATE,
  output logic        O_HALTED,
  output logic [31:0] O_CYCLE_COUNT,
  output logic [31:0] O_STALL_COUNT
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    HALTED    = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   advance;
  logic   load_use;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Halt in WB outranks every other transition out of an advancing state.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (I_DBG_RUN) next_state = I_DBG_MODE ? STEP_WAIT : RUN;
      RUN:       if (I_HALT_WB) next_state = HALTED;
      STEP_WAIT: if (I_DBG_STEP) next_state = STEP_EXEC;
      STEP_EXEC: next_state = I_HALT_WB ? HALTED : STEP_WAIT;
      HALTED:    next_state = HALTED;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    advance  = (state == RUN) || (state == STEP_EXEC);
    load_use = I_IDEX_MemRead && (I_IDEX_RT != '0) &&
               ((I_IDEX_RT == I_IFID_RS) || (I_IDEX_RT == I_IFID_RT));
  end

  // A load-use stall holds PC and IF/ID and suppresses any branch flush.
  always_comb begin
    O_PC_ENABLE    = 1'b0;
    O_IFID_ENABLE  = 1'b0;
    O_IFID_FLUSH   = 1'b0;
    O_IDEX_ENABLE  = 1'b0;
    O_IDEX_BUBBLE  = 1'b0;
    O_EXMEM_ENABLE = 1'b0;
    O_MEMWB_ENABLE = 1'b0;
    O_STATE        = state;
    O_HALTED       = (state == HALTED);
    if (advance) begin
      O_IDEX_ENABLE  = 1'b1;
      O_EXMEM_ENABLE = 1'b1;
      O_MEMWB_ENABLE = 1'b1;
      if (load_use) begin
        O_IDEX_BUBBLE = 1'b1;
      end else begin
        O_PC_ENABLE   = 1'b1;
        O_IFID_ENABLE = 1'b1;
        O_IFID_FLUSH  = I_BRANCH_TAKEN;
      end
    end
  end

`ifdef PIPE_SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_count;
  logic [31:0] stall_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else if (advance) begin
      cycle_count <= cycle_count + 32'd1;
      if (load_use) stall_count <= stall_count + 32'd1;
    end
  end

  assign O_CYCLE_COUNT = cycle_count;
  assign O_STALL_COUNT = stall_count;
`else
  assign O_CYCLE_COUNT = '0;
  assign O_STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: vector table, directed debug sequences and
// randomized traffic against a behavioural model of the run/step/halt and hazard rules.
module tb_pipeline_sequencer;

  logic        clk;
  logic        rst;
  logic        dbg_run, dbg_mode, dbg_step, halt_wb;
  logic        idex_memread, branch_taken;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
  logic [2:0]  state_o;
  logic        halted_o;
  logic [31:0] cycle_cnt, stall_cnt;

  pipeline_sequencer dut (
    .CLK(clk), .RESET(rst),
    .I_DBG_RUN(dbg_run), .I_DBG_MODE(dbg_mode), .I_DBG_STEP(dbg_step),
    .I_HALT_WB(halt_wb), .I_IDEX_MemRead(idex_memread), .I_IDEX_RT(idex_rt),
    .I_IFID_RS(ifid_rs), .I_IFID_RT(ifid_rt), .I_BRANCH_TAKEN(branch_taken),
    .O_PC_ENABLE(pc_en), .O_IFID_ENABLE(ifid_en), .O_IFID_FLUSH(ifid_flush),
    .O_IDEX_ENABLE(idex_en), .O_IDEX_BUBBLE(idex_bubble),
    .O_EXMEM_ENABLE(exmem_en), .O_MEMWB_ENABLE(memwb_en),
    .O_STATE(state_o), .O_HALTED(halted_o),
    .O_CYCLE_COUNT(cycle_cnt), .O_STALL_COUNT(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned adv_seen = 0;

  // Model: debug phase as spec-visible state number plus advancing-cycle tallies.
  int          m_state;
  logic [31:0] m_cyc, m_stall;

  typedef struct {
    logic       mr;
    logic [4:0] xrt, rs, rt;
    logic       br;
    logic [6:0] exp_en; // {pc, ifid, flush, idex, bubble, exmem, memwb}
  } vec_t;

  vec_t vecs[7];

  function automatic logic [6:0] dut_en();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};
  endfunction

  function automatic logic model_adv();
    return (m_state == 1) || (m_state == 3);
  endfunction

  function automatic logic model_lu();
    return idex_memread && (idex_rt != 5'd0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  endfunction

  function automatic logic [6:0] model_en();
    if (!model_adv()) return 7'b0;
    if (model_lu()) return 7'b0001111;
    return {1'b1, 1'b1, branch_taken, 1'b1, 1'b0, 1'b1, 1'b1};
  endfunction

  function automatic logic [31:0] exp_count(input logic [31:0] v);
`ifdef PIPE_SEQ_PERF_COUNTERS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic run, input logic mode, input logic step, input logic halt,
                       input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br);
    dbg_run = run; dbg_mode = mode; dbg_step = step; halt_wb = halt;
    idex_memread = mr; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt; branch_taken = br;
  endtask

  task automatic settle_check();
    #1;
    chk("enables", 32'(dut_en()), 32'(model_en()));
    chk("state", 32'(state_o), 32'(m_state));
    chk("halted", 32'(halted_o), 32'(m_state == 4));
    chk("cycle_count", cycle_cnt, exp_count(m_cyc));
    chk("stall_count", stall_cnt, exp_count(m_stall));
    adv_seen += 32'(idex_en);
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (model_adv()) begin
      m_cyc = m_cyc + 32'd1;
      if (model_lu()) m_stall = m_stall + 32'd1;
    end
    case (m_state)
      0: if (dbg_run) m_state = dbg_mode ? 2 : 1;
      1: if (halt_wb) m_state = 4;
      2: if (dbg_step) m_state = 3;
      3: m_state = halt_wb ? 4 : 2;
      default: ;
    endcase
    #1;
  endtask

  task automatic cyc(input logic run, input logic mode, input logic step, input logic halt,
                     input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                     input logic [4:0] rt, input logic br);
    drive(run, mode, step, halt, mr, xrt, rs, rt, br);
    settle_check();
    edge_update();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    @(posedge clk);
    #1;
    chk("reset_enables", 32'(dut_en()), 32'd0);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_halted", 32'(halted_o), 32'd0);
    chk("reset_cycle_count", cycle_cnt, 32'd0);
    chk("reset_stall_count", stall_cnt, 32'd0);
    m_state = 0; m_cyc = '0; m_stall = '0; adv_seen = 0;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mr: 1'b0, xrt: 5'd0,  rs: 5'd1,  rt: 5'd2,  br: 1'b0, exp_en: 7'b1101011};
    vecs[1] = '{mr: 1'b1, xrt: 5'd5,  rs: 5'd5,  rt: 5'd9,  br: 1'b0, exp_en: 7'b0001111};
    vecs[2] = '{mr: 1'b1, xrt: 5'd0,  rs: 5'd0,  rt: 5'd0,  br: 1'b0, exp_en: 7'b1101011};
    vecs[3] = '{mr: 1'b1, xrt: 5'd7,  rs: 5'd7,  rt: 5'd3,  br: 1'b1, exp_en: 7'b0001111};
    vecs[4] = '{mr: 1'b0, xrt: 5'd7,  rs: 5'd7,  rt: 5'd3,  br: 1'b1, exp_en: 7'b1111011};
    vecs[5] = '{mr: 1'b1, xrt: 5'd12, rs: 5'd4,  rt: 5'd12, br: 1'b0, exp_en: 7'b0001111};
    vecs[6] = '{mr: 1'b1, xrt: 5'd31, rs: 5'd30, rt: 5'd29, br: 1'b1, exp_en: 7'b1111011};

    rst = 1'b1;
    m_state = 0; m_cyc = '0; m_stall = '0;
    reset_dut();

    // Start continuous run: enables only from the cycle after the start edge.
    cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("run_state", 32'(state_o), 32'd1);

    foreach (vecs[i]) begin
      drive(0, 0, 0, 0, vecs[i].mr, vecs[i].xrt, vecs[i].rs, vecs[i].rt, vecs[i].br);
      #1;
      chk($sformatf("table_vec%0d", i), 32'(dut_en()), 32'(vecs[i].exp_en));
      #0 settle_check();
      edge_update();
    end

    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 0, 1'($urandom),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom));
    end

    // Ten advancing cycles then a halt cycle: eleven counted, then frozen.
    reset_dut();
    cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 10; i++) idle_cyc();
    drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    #1;
    chk("halt_cycle_enables", 32'(dut_en()), 32'h6B);
    settle_check();
    edge_update();
    for (int i = 0; i < 4; i++) cyc(1, i[0], 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("halted_flag", 32'(halted_o), 32'd1);
    chk("halted_state", 32'(state_o), 32'd4);
    chk("halted_enables", 32'(dut_en()), 32'd0);
    chk("halted_cycle_count", cycle_cnt, exp_count(32'd11));

    // Asynchronous reset between edges while running.
    reset_dut();
    cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 3; i++) idle_cyc();
    cyc(0, 0, 0, 0, 1, 5'd6, 5'd6, 5'd0, 0);
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    #1;
    chk("pre_reset_enables", 32'(dut_en()), 32'h6B);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_enables", 32'(dut_en()), 32'd0);
    chk("async_reset_state", 32'(state_o), 32'd0);
    chk("async_reset_cycle_count", cycle_cnt, 32'd0);
    chk("async_reset_stall_count", stall_cnt, 32'd0);
    m_state = 0; m_cyc = '0; m_stall = '0;
    #2 rst = 1'b0;
    edge_update();
    idle_cyc();

    // Single-step: three pulses four cycles apart give exactly three advancing cycles.
    reset_dut();
    cyc(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("step_wait_state", 32'(state_o), 32'd2);
    adv_seen = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      for (int j = 0; j < 3; j++) idle_cyc();
    end
    chk("step_advance_cycles", adv_seen, 32'd3);
    chk("step_cycle_count", cycle_cnt, exp_count(32'd3));

    // Random stepping with frequent load-use hazards consuming steps.
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0), 0, 1'($urandom),
          5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
          1'($urandom));
    end
    cyc(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle_cyc();
    cyc(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
